// File: rtl/mem_alloc_pkg.sv
// Shared definitions for the multi-requester block allocator:
// block count derivation, default block-address type and reset constants.
package mem_alloc_pkg;

    localparam int unsigned AWIDTH_DEF = 10;

    typedef logic [AWIDTH_DEF-1:0] blk_addr_t;

    // Number of blocks tracked for a given address width.
    function automatic int unsigned nblk(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // After reset every block is free.
    function automatic int unsigned rst_free_cnt(input int unsigned aw);
        return nblk(aw);
    endfunction

    localparam logic RST_FULL        = 1'b0;
    localparam logic RST_ALMOST_FULL = 1'b0;  // holds while AF_THRESH < NBLK
    localparam logic RST_EMPTY       = 1'b1;

endpackage

// File: rtl/blk_bitmap.sv
// Occupancy bitmap (1 = occupied) with lowest-free finder, set/clear ports
// and optional double-free detection (MEM_ALLOC_DBLFREE_CHK_EN).
module blk_bitmap
    import mem_alloc_pkg::*;
#(
    parameter int unsigned AWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set_vld,
    input  logic [AWIDTH-1:0] i_set_addr,
    input  logic              i_clr_vld,
    input  logic [AWIDTH-1:0] i_clr_addr,
    output logic [AWIDTH-1:0] o_free_addr,
    output logic              o_clr_ok,
    output logic              o_rls_err
);

    localparam int unsigned NBLK = nblk(AWIDTH);

    logic [NBLK-1:0]   r_bitmap;
    logic [NBLK-1:0]   w_bitmap_d;
    logic              w_clr_ok;
    logic [AWIDTH-1:0] w_free_addr;

`ifdef MEM_ALLOC_DBLFREE_CHK_EN
    logic w_dbl_free;
    logic r_rls_err;

    // A release of a block that is already free is dropped and flagged.
    assign w_clr_ok   = i_clr_vld & r_bitmap[i_clr_addr];
    assign w_dbl_free = i_clr_vld & ~r_bitmap[i_clr_addr];

    // Double-free pulse, aligned with the edge the release would have used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rls_err <= 1'b0;
        end else begin
            r_rls_err <= w_dbl_free;
        end
    end

    assign o_rls_err = r_rls_err;
`else
    assign w_clr_ok  = i_clr_vld;
    assign o_rls_err = 1'b0;
`endif

    // Lowest-index free block; descending scan so the lowest index wins.
    always_comb begin
        w_free_addr = '0;
        for (int i = int'(NBLK) - 1; i >= 0; i--) begin
            if (!r_bitmap[i]) begin
                w_free_addr = AWIDTH'(i);
            end
        end
    end

    // Next bitmap: clear first so a conflicting set on the same bit wins.
    always_comb begin
        w_bitmap_d = r_bitmap;
        if (w_clr_ok) begin
            w_bitmap_d[i_clr_addr] = 1'b0;
        end
        if (i_set_vld) begin
            w_bitmap_d[i_set_addr] = 1'b1;
        end
    end

    // Bitmap register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitmap <= '0;
        end else begin
            r_bitmap <= w_bitmap_d;
        end
    end

    assign o_free_addr = w_free_addr;
    assign o_clr_ok    = w_clr_ok;

endmodule

// File: rtl/mem_block_alloc.sv
// Multi-requester block allocator: round-robin arbitration over NREQ ports,
// registered grant, free-block counter and occupancy flags.
// Optional double-free detection is enabled by defining MEM_ALLOC_DBLFREE_CHK_EN.
module mem_block_alloc
    import mem_alloc_pkg::*;
#(
    parameter int unsigned AWIDTH    = 10,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned AF_THRESH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   ocp_req,
    output logic [NREQ-1:0]   ocp_ack,
    output logic [AWIDTH-1:0] ocp_addr,
    input  logic              rls_vld,
    input  logic [AWIDTH-1:0] rls_addr,
    output logic [AWIDTH:0]   free_cnt,
    output logic              full,
    output logic              almost_full,
    output logic              empty,
    output logic              rls_err
);

    localparam int unsigned RRW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AWIDTH:0] CNT_RST = (AWIDTH+1)'(rst_free_cnt(AWIDTH));
    localparam logic [AWIDTH:0] CNT_MAX = (AWIDTH+1)'(nblk(AWIDTH));

    logic [NREQ-1:0]   r_ack;
    logic [AWIDTH-1:0] r_addr;
    logic [AWIDTH:0]   r_cnt;
    logic [RRW-1:0]    r_rr;

    logic [NREQ-1:0]   w_elig;
    logic              w_hi_vld;
    logic [RRW-1:0]    w_hi_idx;
    logic              w_lo_vld;
    logic [RRW-1:0]    w_lo_idx;
    logic              w_gnt;
    logic [RRW-1:0]    w_gnt_idx;
    logic [RRW-1:0]    w_rr_d;
    logic [NREQ-1:0]   w_ack_d;
    logic [AWIDTH:0]   w_cnt_d;
    logic [AWIDTH-1:0] w_free_addr;
    logic              w_clr_ok;
    logic              w_full;

    blk_bitmap #(
        .AWIDTH (AWIDTH)
    ) u_bitmap (
        .clk         (clk),
        .rst         (rst),
        .i_set_vld   (w_gnt),
        .i_set_addr  (w_free_addr),
        .i_clr_vld   (rls_vld),
        .i_clr_addr  (rls_addr),
        .o_free_addr (w_free_addr),
        .o_clr_ok    (w_clr_ok),
        .o_rls_err   (rls_err)
    );

    // A port being acked this cycle is masked so its held req is not re-served.
    assign w_elig = ocp_req & ~r_ack;
    assign w_full = (r_cnt == '0);

    // Round-robin pick: lowest eligible index at or above rr, else lowest overall.
    always_comb begin
        w_hi_vld = 1'b0;
        w_hi_idx = '0;
        w_lo_vld = 1'b0;
        w_lo_idx = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (w_elig[i] && (i >= int'(r_rr))) begin
                w_hi_vld = 1'b1;
                w_hi_idx = RRW'(i);
            end
            if (w_elig[i]) begin
                w_lo_vld = 1'b1;
                w_lo_idx = RRW'(i);
            end
        end
        w_gnt     = (w_hi_vld | w_lo_vld) & ~w_full;
        w_gnt_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
    end

    // Grant decode, pointer advance and free-count update.
    always_comb begin
        w_ack_d = '0;
        w_rr_d  = r_rr;
        if (w_gnt) begin
            w_ack_d[w_gnt_idx] = 1'b1;
            w_rr_d = (w_gnt_idx == RRW'(NREQ - 1)) ? '0 : w_gnt_idx + RRW'(1);
        end
        w_cnt_d = r_cnt;
        unique case ({w_clr_ok, w_gnt})
            2'b10:   w_cnt_d = r_cnt + 1'b1;
            2'b01:   w_cnt_d = r_cnt - 1'b1;
            default: w_cnt_d = r_cnt;
        endcase
    end

    // Grant outputs, round-robin pointer and free counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack  <= '0;
            r_addr <= '0;
            r_cnt  <= CNT_RST;
            r_rr   <= '0;
        end else begin
            r_ack  <= w_ack_d;
            r_addr <= w_gnt ? w_free_addr : '0;
            r_cnt  <= w_cnt_d;
            r_rr   <= w_rr_d;
        end
    end

    assign ocp_ack     = r_ack;
    assign ocp_addr    = r_addr;
    assign free_cnt    = r_cnt;
    assign full        = w_full;
    assign almost_full = (32'(r_cnt) <= AF_THRESH);
    assign empty       = (r_cnt == CNT_MAX);

endmodule

// File: doc/mem_block_alloc.md
# mem_block_alloc

Multi-requester block allocator for the shared packet SRAM: tracks occupancy of `2**AWIDTH` fixed-size blocks in an internal bitmap and hands out free block addresses to `NREQ` write ports. Allocation uses round-robin arbitration; releases come from the read side. It sits between the per-port write controllers and the SRAM address path, and replaces the single-requester manager with a parametrised multi-port version. The multi-port version adds almost-full thresholding and optional double-free detection.

## Interface
Parameters:
- `AWIDTH`, 10, block address width; `NBLK = 2**AWIDTH` blocks
- `NREQ`, 4, number of allocation requesters (≥1)
- `AF_THRESH`, 8, `almost_full` asserts when free count ≤ this value

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ocp_req`  in  NREQ  per-port allocation request, level
- `ocp_ack`  out  NREQ  one-hot grant pulse, one cycle
- `ocp_addr`  out  AWIDTH  granted block address, valid while any `ocp_ack` is high, else 0
- `rls_vld`  in  1  release strobe
- `rls_addr`  in  AWIDTH  block to release
- `free_cnt`  out  AWIDTH+1  number of free blocks
- `full`  out  1  `free_cnt == 0`
- `almost_full`  out  1  `free_cnt <= AF_THRESH`
- `empty`  out  1  `free_cnt == NBLK`, meaning all blocks are free
- `rls_err`  out  1  double-free pulse; tied to 0 unless the `_EN` macro below is defined

## Operation
- Bitmap: one bit per block, 1 = occupied. Reset clears all bits.
- Free-block selection: lowest-index 0 bit in the bitmap, computed combinationally each cycle.
- Arbitration:
  - Eligible ports: `ocp_req[i] & ~ocp_ack[i]`. A port being acked in a cycle is masked that cycle, so each port gets at most one block per 2 cycles.
  - Round-robin pointer `rr`. Search starts at `rr`; after a grant to port i, `rr <= (i+1) mod NREQ`.
  - At most one grant per cycle. No grant when `full`.
- Grant:
  - Registered: `ocp_ack[i]` and `ocp_addr` are driven on the cycle after the request is sampled.
  - In the same edge, the chosen bitmap bit is set and `free_cnt` is decremented.
- Requester contract: hold `ocp_req` until ack is seen. Drop `ocp_req` in the ack cycle unless another block is wanted; a still-high req is treated as a new request from the next cycle.
- Release: on `rls_vld`, bit `rls_addr` is cleared and `free_cnt` is incremented at the next edge. The freed block becomes selectable from the cycle after that edge.
- Simultaneous grant and release: both take effect; net `free_cnt` is unchanged. The released block is not eligible for the same-cycle grant.
- Flags: `full`, `almost_full` and `empty` are derived combinationally from the registered `free_cnt`.
- Width rule: `free_cnt` spans 0..NBLK inclusive, hence AWIDTH+1 bits; never wraps.

## Timing
- Reset values:
  - `ocp_ack` = 0, `ocp_addr` = 0, `rls_err` = 0
  - `free_cnt` = NBLK, `full` = 0, `almost_full` = 0 (`AF_THRESH < NBLK`), `empty` = 1
  - `rr` = 0
- Latency:
  - req high at edge N → `ocp_ack` at N+1.
  - `rls_vld` at edge N → `free_cnt` updated at N+1, block selectable for a grant at N+2.
- Full: requests wait with no timeout. A release while full produces a grant one cycle after `free_cnt` becomes nonzero.
- Reset mid-operation: all state returns to reset values immediately; an in-flight ack is dropped.

## Configuration
- `MEM_ALLOC_DBLFREE_CHK_EN` defined:
  - A release of an already-free block is ignored: bitmap and count are unchanged.
  - `rls_err` pulses for one cycle, aligned with the edge at which the release would have taken effect.
- Not defined:
  - Release clears the bit and increments `free_cnt` unconditionally.
  - Double-free is a caller contract violation and corrupts the count.
  - `rls_err` is constant 0.

## Structure
- Shared package `mem_alloc_pkg`:
  - `NBLK` derivation function
  - block-address typedef
  - reset constants for count and flags
- Sub-module `blk_bitmap` holds the bitmap register, the lowest-zero finder, the set/clear ports and the double-free check.
- The top level holds the round-robin arbiter, the grant registers, the counter and the flags.

## Test plan
- Reset, then all 4 ports request continuously with `AWIDTH=4` → acks rotate 0,1,2,3,…, addresses 0..15 in order, `full=1` after the 16th grant, `free_cnt=0`.
- Full, then release addr 5 → `free_cnt=1` next cycle, waiting port acked with `ocp_addr=5` one cycle later, `full` re-asserts.
- Grant and release of addr 2 in the same cycle at `free_cnt=7` → `free_cnt` stays 7, addr 2 granted no earlier than the following cycle.
- `AF_THRESH=8`, allocate 8 of 16 blocks → `almost_full` rises exactly when `free_cnt` reaches 8, falls after the next release.
- With `MEM_ALLOC_DBLFREE_CHK_EN`, release the free addr 9 → `rls_err` one-cycle pulse, `free_cnt` unchanged. Without the macro, `free_cnt` increments and `rls_err` stays 0.
- Assert `rst` mid-grant → `ocp_ack=0`, `free_cnt=NBLK`, `empty=1` immediately. The first grant after reset returns addr 0 to port 0.
